// File: rtl/mat_collect.sv
// mat_collect: packs 32-bit elements row-major into an M x N matrix and presents it whole.
// Build option MAT_COLLECT_DBUF_EN lets collection of the next matrix overlap presentation.
module mat_collect #(
  parameter int M = 1,
  parameter int N = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               input_elem,
  input  logic                      input_elem_stb,
  output logic                      input_elem_ack,
  output logic [M-1:0][N-1:0][31:0] output_mat,
  output logic                      output_mat_stb,
  input  logic                      output_mat_ack
);
  localparam int TOTAL = M * N;
  localparam int CW = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  typedef enum logic {COLLECT, PUT_MAT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [TOTAL-1:0][31:0] asm_mat;
  logic [TOTAL-1:0][31:0] full_mat;
  logic                   elem_xfer;
  logic                   mat_xfer;
  logic                   last_elem;

  assign elem_xfer = input_elem_stb && input_elem_ack;
  assign mat_xfer  = output_mat_stb && output_mat_ack;
  assign last_elem = (cnt == LAST);

  // Assembly contents with the incoming word dropped into the current slot.
  genvar gi;
  generate
    for (gi = 0; gi < TOTAL; gi++) begin : g_slot
      assign full_mat[gi] = (cnt == CW'(gi)) ? input_elem : asm_mat[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= COLLECT;
      cnt            <= '0;
      input_elem_ack <= 1'b0;
      output_mat_stb <= 1'b0;
      output_mat     <= '0;
    end else begin
`ifdef MAT_COLLECT_DBUF_EN
      if (mat_xfer) begin
        output_mat_stb <= 1'b0;
        state          <= COLLECT;
      end
      if (elem_xfer) begin
        input_elem_ack <= 1'b0;
        asm_mat        <= full_mat;
        if (last_elem) begin
          output_mat     <= full_mat;
          output_mat_stb <= 1'b1;
          state          <= PUT_MAT;
          cnt            <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // Hold off the final word while the previous matrix is still pending.
        input_elem_ack <= !((state == PUT_MAT) && (last_elem || mat_xfer));
      end
`else
      case (state)
        COLLECT: begin
          if (elem_xfer) begin
            input_elem_ack <= 1'b0;
            asm_mat        <= full_mat;
            if (last_elem) begin
              output_mat     <= full_mat;
              output_mat_stb <= 1'b1;
              state          <= PUT_MAT;
              cnt            <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            input_elem_ack <= 1'b1;
          end
        end
        PUT_MAT: begin
          input_elem_ack <= 1'b0;
          if (mat_xfer) begin
            output_mat_stb <= 1'b0;
            state          <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
`endif
    end
  end
endmodule
